// File: rtl/brick_pkg.sv
// Shared constants and types for the brick wall.
// BRICK_MULTIHIT_EN widens hit-point storage so upper rows take several hits.
package brick_pkg;

  localparam int ROWS_DEF     = 4;
  localparam int COLS_DEF     = 10;
  localparam int MAX_HITS_DEF = 3;

  localparam logic [7:0] KEY_RESTART = 8'h15;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    PLAY    = 2'd1,
    CLEARED = 2'd2
  } field_state_t;

`ifdef BRICK_MULTIHIT_EN
  localparam int HP_W = $clog2(MAX_HITS_DEF + 1);
`else
  localparam int HP_W = 1;
`endif

  // Rows nearer the top are tougher; nothing starts below one hit point.
  function automatic int init_hits(input int row, input int max_hits);
    int hits;
    hits = max_hits - row;
    if (hits < 1) begin
      hits = 1;
    end else begin
      hits = hits;
    end
    return hits;
  endfunction

endpackage

// File: rtl/brick_field_if.sv
// Break-request channel from the ball block into the brick field.
interface brick_field_if;
  logic Brick_Broke;
  int   BreakX;
  int   BreakY;

  modport master (output Brick_Broke, BreakX, BreakY);
  modport slave  (input  Brick_Broke, BreakX, BreakY);
endinterface

// File: rtl/brick_fill_seq.sv
// Fill-index sweep over the wall, decoded into row/column with a last-cell flag.
module brick_fill_seq
  import brick_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF,
  parameter int RW   = 2,
  parameter int CW   = 4
) (
  input  logic          frame_clk,
  input  logic          Reset,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [RW-1:0] row_o,
  output logic [CW-1:0] col_o,
  output logic          done_o
);

  localparam int CELLS = ROWS * COLS;
  localparam int IW    = (CELLS > 1) ? $clog2(CELLS) : 1;

  logic [IW-1:0] idx_q;
  logic [IW-1:0] idx_d;

  assign done_o = (idx_q == IW'(CELLS - 1));
  assign row_o  = RW'(int'(idx_q) / COLS);
  assign col_o  = CW'(int'(idx_q) % COLS);

  // Next index: clear wins, otherwise step while filling and wrap after the last cell.
  always_comb begin
    idx_d = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (en_i) begin
      idx_d = done_o ? '0 : idx_q + IW'(1);
    end else begin
      idx_d = idx_q;
    end
  end

  // Index register.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/brick_field.sv
// Brick wall owner: builds the wall, validates break requests, keeps score.
// BRICK_MULTIHIT_EN gives row r max(MAX_HITS - r, 1) hit points instead of one.
module brick_field
  import brick_pkg::*;
#(
  parameter int ROWS     = ROWS_DEF,
  parameter int COLS     = COLS_DEF,
  parameter int MAX_HITS = MAX_HITS_DEF
) (
  input  logic                frame_clk,
  input  logic                Reset,
  input  logic [7:0]          key,
  brick_field_if.slave        ball,
  output int                  Bricks [ROWS][COLS],
  output logic [5:0]          bricks_left,
  output logic                field_ready,
  output logic                field_cleared,
  output logic                brick_destroyed,
  output logic [15:0]         score
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  typedef logic [HP_W-1:0] hp_t;

  if (MAX_HITS < 1) begin : g_max_hits_low
    $error("brick_field: MAX_HITS must be at least 1");
  end
`ifdef BRICK_MULTIHIT_EN
  if ((MAX_HITS >> HP_W) != 0) begin : g_max_hits_wide
    $error("brick_field: MAX_HITS does not fit the hit-point width");
  end
`endif

  field_state_t state_q, state_d;
  hp_t          hp_q [ROWS][COLS];
  hp_t          hp_d [ROWS][COLS];
  logic [5:0]   left_q, left_d;
  logic [15:0]  score_q, score_d;
  logic         destroyed_q, destroyed_d;
  logic         ready_q, cleared_q;

  logic          restart_s;
  logic          fill_done_s;
  logic [RW-1:0] fill_row_s;
  logic [CW-1:0] fill_col_s;
  logic          req_in_range_s;
  logic          req_ok_s;
  logic [RW-1:0] req_row_s;
  logic [CW-1:0] req_col_s;
  hp_t           req_hp_s;

  assign restart_s = (key == KEY_RESTART);

  brick_fill_seq #(
    .ROWS (ROWS),
    .COLS (COLS),
    .RW   (RW),
    .CW   (CW)
  ) u_fill_seq (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .clr_i     (restart_s),
    .en_i      (state_q == FILL),
    .row_o     (fill_row_s),
    .col_o     (fill_col_s),
    .done_o    (fill_done_s)
  );

  // Coordinates are truncated for indexing only after the range check gates them.
  assign req_in_range_s = (ball.BreakX >= 0) && (ball.BreakX < ROWS) &&
                          (ball.BreakY >= 0) && (ball.BreakY < COLS);
  assign req_row_s      = ball.BreakX[RW-1:0];
  assign req_col_s      = ball.BreakY[CW-1:0];
  assign req_hp_s       = req_in_range_s ? hp_q[req_row_s][req_col_s] : '0;
  assign req_ok_s       = ball.Brick_Broke && req_in_range_s && (req_hp_s != '0);

  // Next-state: restart first, then fill sweep or request handling by state.
  always_comb begin
    state_d     = state_q;
    hp_d        = hp_q;
    left_d      = left_q;
    score_d     = score_q;
    destroyed_d = 1'b0;
    if (restart_s) begin
      state_d = FILL;
      hp_d    = '{default: '0};
      left_d  = 6'd0;
      score_d = 16'd0;
    end else begin
      case (state_q)
        FILL: begin
`ifdef BRICK_MULTIHIT_EN
          hp_d[fill_row_s][fill_col_s] = hp_t'(init_hits(int'(fill_row_s), MAX_HITS));
`else
          hp_d[fill_row_s][fill_col_s] = 1'b1;
`endif
          left_d = left_q + 6'd1;
          if (fill_done_s) begin
            state_d = PLAY;
          end else begin
            state_d = FILL;
          end
        end
        PLAY: begin
          if (req_ok_s) begin
            hp_d[req_row_s][req_col_s] = req_hp_s - hp_t'(1);
            score_d = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;
            if (req_hp_s == hp_t'(1)) begin
              destroyed_d = 1'b1;
              left_d      = left_q - 6'd1;
              state_d     = (left_q == 6'd1) ? CLEARED : PLAY;
            end else begin
              destroyed_d = 1'b0;
            end
          end else begin
            state_d = PLAY;
          end
        end
        CLEARED: state_d = CLEARED;
        default: state_d = FILL;
      endcase
    end
  end

  // State, wall and counter registers; status flags follow the next state.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= FILL;
      hp_q        <= '{default: '0};
      left_q      <= 6'd0;
      score_q     <= 16'd0;
      destroyed_q <= 1'b0;
      ready_q     <= 1'b0;
      cleared_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hp_q        <= hp_d;
      left_q      <= left_d;
      score_q     <= score_d;
      destroyed_q <= destroyed_d;
      ready_q     <= (state_d == PLAY);
      cleared_q   <= (state_d == CLEARED);
    end
  end

  // Publish presence per cell for the ball's collision logic.
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        Bricks[r][c] = int'(hp_q[r][c] != '0);
      end
    end
  end

  assign bricks_left     = left_q;
  assign score           = score_q;
  assign brick_destroyed = destroyed_q;
  assign field_ready     = ready_q;
  assign field_cleared   = cleared_q;

endmodule

// File: tb/tb_brick_field.sv
// Directed bench for brick_field against a per-cell hit-point model.
// Honours BRICK_MULTIHIT_EN the same way as the design.
module tb_brick_field;

  localparam int ROWS  = 4;
  localparam int COLS  = 10;
  localparam int CELLS = ROWS * COLS;

  logic        frame_clk = 1'b0;
  logic        Reset     = 1'b1;
  logic [7:0]  key       = 8'h00;
  int          Bricks [ROWS][COLS];
  logic [5:0]  bricks_left;
  logic        field_ready;
  logic        field_cleared;
  logic        brick_destroyed;
  logic [15:0] score;

  brick_field_if ball ();

  brick_field #(
    .ROWS     (ROWS),
    .COLS     (COLS),
    .MAX_HITS (3)
  ) dut (
    .frame_clk       (frame_clk),
    .Reset           (Reset),
    .key             (key),
    .ball            (ball),
    .Bricks          (Bricks),
    .bricks_left     (bricks_left),
    .field_ready     (field_ready),
    .field_cleared   (field_cleared),
    .brick_destroyed (brick_destroyed),
    .score           (score)
  );

  always #5 frame_clk = ~frame_clk;

  int checks   = 0;
  int failures = 0;

  // Model: hit points per cell, fill position, phase 0=fill 1=play 2=cleared.
  int m_hp [ROWS][COLS];
  int m_idx;
  int m_phase;
  int m_score;
  int m_destroyed;

  function automatic int start_hits(input int r);
`ifdef BRICK_MULTIHIT_EN
    return (3 - r > 1) ? 3 - r : 1;
`else
    return 1;
`endif
  endfunction

  function automatic int m_left();
    int n;
    n = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (m_hp[r][c] > 0) n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        m_hp[r][c] = 0;
    m_idx = 0;
    m_phase = 0;
    m_score = 0;
    m_destroyed = 0;
  endtask

  task automatic model_step();
    int x, y;
    x = ball.BreakX;
    y = ball.BreakY;
    m_destroyed = 0;
    if (key == 8'h15) begin
      model_reset();
    end else if (m_phase == 0) begin
      m_hp[m_idx / COLS][m_idx % COLS] = start_hits(m_idx / COLS);
      m_idx++;
      if (m_idx == CELLS) m_phase = 1;
    end else if (m_phase == 1) begin
      if (ball.Brick_Broke && x >= 0 && x < ROWS && y >= 0 && y < COLS && m_hp[x][y] > 0) begin
        m_hp[x][y]--;
        if (m_score < 65535) m_score++;
        if (m_hp[x][y] == 0) begin
          m_destroyed = 1;
          if (m_left() == 0) m_phase = 2;
        end
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge frame_clk);
    model_step();
    #1;
  endtask

  task automatic set_req(input logic b, input int x, input int y);
    ball.Brick_Broke = b;
    ball.BreakX      = x;
    ball.BreakY      = y;
  endtask

  // Compare every output against the model on each falling edge.
  initial begin
    forever begin
      int bad_r, bad_c;
      @(negedge frame_clk);
      chk("cmp_bricks_left", int'(bricks_left), m_left());
      chk("cmp_score", int'(score), m_score);
      chk("cmp_field_ready", int'(field_ready), int'(m_phase == 1));
      chk("cmp_field_cleared", int'(field_cleared), int'(m_phase == 2));
      chk("cmp_brick_destroyed", int'(brick_destroyed), m_destroyed);
      bad_r = -1;
      bad_c = -1;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          if (bad_r < 0 && Bricks[r][c] != int'(m_hp[r][c] > 0)) begin
            bad_r = r;
            bad_c = c;
          end
      if (bad_r < 0) begin
        chk("cmp_bricks", 0, 0 * bad_c);
      end else begin
        chk($sformatf("cmp_bricks[%0d][%0d]", bad_r, bad_c), Bricks[bad_r][bad_c],
            int'(m_hp[bad_r][bad_c] > 0));
      end
    end
  end

  initial begin
    model_reset();
    set_req(1'b0, 0, 0);
    #12;
    chk("rst_left", int'(bricks_left), 0);
    chk("rst_ready", int'(field_ready), 0);
    chk("rst_score", int'(score), 0);
    chk("rst_brick00", Bricks[0][0], 0);
    Reset = 1'b0;

    for (int i = 1; i <= CELLS; i++) begin
      tick();
      chk("fill_left", int'(bricks_left), i);
      chk("fill_ready", int'(field_ready), int'(i == CELLS));
    end
    chk("fill_b39", Bricks[3][9], 1);
    chk("fill_score", int'(score), 0);

    set_req(1'b1, 2, 5);
    tick();
    chk("hit25_brick", Bricks[2][5], 0);
    chk("hit25_left", int'(bricks_left), 39);
    chk("hit25_pulse", int'(brick_destroyed), 1);
    chk("hit25_score", int'(score), 1);
    tick();
    chk("rehit25_pulse", int'(brick_destroyed), 0);
    chk("rehit25_left", int'(bricks_left), 39);
    chk("rehit25_score", int'(score), 1);

    set_req(1'b1, 4, 0);
    tick();
    set_req(1'b1, 0, 10);
    tick();
    set_req(1'b1, -1, 3);
    tick();
    chk("oor_left", int'(bricks_left), 39);
    chk("oor_score", int'(score), 1);

`ifdef BRICK_MULTIHIT_EN
    for (int k = 1; k <= 3; k++) begin
      set_req(1'b1, 0, 0);
      tick();
      chk("multi_score", int'(score), 1 + k);
      chk("multi_brick00", Bricks[0][0], int'(k < 3));
      chk("multi_pulse", int'(brick_destroyed), int'(k == 3));
    end
`endif

    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        for (int g = 0; g < 4 && m_hp[r][c] > 0; g++) begin
          set_req(1'b1, r, c);
          tick();
        end
    set_req(1'b0, 0, 0);
    chk("clr_cleared", int'(field_cleared), 1);
    chk("clr_pulse", int'(brick_destroyed), 1);
    chk("clr_left", int'(bricks_left), 0);
`ifdef BRICK_MULTIHIT_EN
    chk("clr_score", int'(score), 70);
`else
    chk("clr_score", int'(score), 40);
`endif
    tick();
    chk("clr_pulse_end", int'(brick_destroyed), 0);
    chk("clr_hold", int'(field_cleared), 1);

    key = 8'h15;
    set_req(1'b1, 1, 1);
    tick();
    key = 8'h00;
    set_req(1'b0, 0, 0);
    chk("restart_cleared", int'(field_cleared), 0);
    chk("restart_ready", int'(field_ready), 0);
    chk("restart_score", int'(score), 0);
    chk("restart_left", int'(bricks_left), 0);

    repeat (5) tick();
    chk("refill5_left", int'(bricks_left), 5);
    key = 8'h15;
    tick();
    key = 8'h00;
    chk("midfill_restart_left", int'(bricks_left), 0);
    chk("midfill_restart_b00", Bricks[0][0], 0);
    tick();
    chk("resweep_left", int'(bricks_left), 1);
    chk("resweep_b01", Bricks[0][1], 0);
    repeat (16) tick();
    chk("fill17_left", int'(bricks_left), 17);

    #1;
    Reset = 1'b1;
    model_reset();
    #1;
    chk("async_rst_left", int'(bricks_left), 0);
    chk("async_rst_b00", Bricks[0][0], 0);
    chk("async_rst_ready", int'(field_ready), 0);
    #5;
    Reset = 1'b0;
    tick();
    chk("post_rst_left", int'(bricks_left), 1);
    chk("post_rst_b00", Bricks[0][0], 1);
    chk("post_rst_b17", Bricks[1][7], 0);
    repeat (CELLS - 1) tick();
    chk("post_rst_ready", int'(field_ready), 1);
    chk("post_rst_full", int'(bricks_left), 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
